// File: rtl/ahb_lite_mem_slave_pkg.sv
// Shared definitions for the AHB-Lite memory slave: HSIZE/HRESP/HTRANS
// encodings, the data-phase state type and the little-endian lane decode.
package ahb_lite_mem_slave_pkg;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_ERR1,
    S_ERR2
  } slave_state_t;

  // Little-endian byte enables for a legal (already aligned) transfer.
  function automatic logic [3:0] lane_enable(input logic [2:0] size,
                                             input logic [1:0] addr_lo);
    logic [3:0] be;
    case (size)
      HSIZE_BYTE: be = 4'b0001 << addr_lo;
      HSIZE_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
      default:    be = 4'b1111;
    endcase
    return be;
  endfunction

  // Size/alignment part of the error decode; range is checked by the slave.
  function automatic logic size_align_err(input logic [2:0] size,
                                          input logic [1:0] addr_lo);
    logic err;
    case (size)
      HSIZE_BYTE: err = 1'b0;
      HSIZE_HALF: err = addr_lo[0];
      HSIZE_WORD: err = (addr_lo != 2'b00);
      default:    err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/ahb_lite_mem_slave_sram_array.sv
// Word-organised storage for the AHB-Lite memory slave.
// Ports:
//   clk    in   write clock
//   we     in   write strobe
//   be     in   4-bit byte enable, bit i covers wdata[8*i +: 8]
//   addr   in   word address (shared by read and write)
//   wdata  in   write data
//   rdata  out  asynchronous read of mem[addr]
// Contents are not reset.
module ahb_lite_sram_array #(
  parameter int MEM_WORDS = 256,
  parameter int AW        = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [MEM_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ahb_lite_mem_slave.sv
// AHB-Lite 32-bit memory slave with byte/halfword/word access, a fixed
// number of wait states per OKAY data phase and the two-cycle ERROR reply.
// Ports:
//   HCLK, HRESETn  clock and synchronous active-low reset
//   HSEL, HADDR, HWRITE, HSIZE, HTRANS, HREADY  address phase inputs
//   HBURST, HPROT, HMASTLOCK  accepted but ignored
//   HWDATA         write data (data phase)
//   HRDATA         read data, zero outside a read ACCESS cycle
//   HREADYOUT      low during WAIT and ERR1
//   HRESP          ERROR during ERR1/ERR2, else OKAY
module ahb_lite_mem_slave
  import ahb_lite_mem_slave_pkg::*;
#(
  parameter int MEM_WORDS   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [1:0]  HTRANS,
  input  logic [3:0]  HPROT,
  input  logic        HMASTLOCK,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);

  localparam int          AW        = $clog2(MEM_WORDS);
  localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);
  localparam logic [2:0]  WS_LAST   = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  slave_state_t  state, state_next;
  logic [2:0]    wait_cnt, wait_cnt_next;
  logic [AW+1:0] addr_q;
  logic          write_q;
  logic [2:0]    size_q;

  logic          can_accept;
  logic          accept;
  logic          addr_err;
  logic          mem_we;
  logic [3:0]    mem_be;
  logic [31:0]   mem_rdata;

  logic          unused_inputs;
  assign unused_inputs = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

  // Address phases are only taken while this slave is itself ready, so a
  // stray HREADY during WAIT/ERR1 cannot overwrite the pending phase.
  always_comb begin
    can_accept = (state == S_IDLE) || (state == S_ACCESS) || (state == S_ERR2);
    accept     = can_accept && HSEL && HREADY && HTRANS[1];
    addr_err   = size_align_err(HSIZE, HADDR[1:0]) || (HADDR >= MEM_BYTES);
  end

  // The error flag is folded into the state: an errored accept goes to ERR1
  // and never reaches ACCESS, so no separate flag register is needed.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    case (state)
      S_IDLE, S_ACCESS, S_ERR2: begin
        if (accept) begin
          if (addr_err) begin
            state_next = S_ERR1;
          end else if (WAIT_STATES != 0) begin
            state_next    = S_WAIT;
            wait_cnt_next = '0;
          end else begin
            state_next = S_ACCESS;
          end
        end else begin
          state_next = S_IDLE;
        end
      end
      S_WAIT: begin
        if (wait_cnt == WS_LAST) begin
          state_next    = S_ACCESS;
          wait_cnt_next = '0;
        end else begin
          wait_cnt_next = wait_cnt + 3'd1;
        end
      end
      S_ERR1:  state_next = S_ERR2;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= '0;
    end else if (accept) begin
      addr_q  <= HADDR[AW+1:0];
      write_q <= HWRITE;
      size_q  <= HSIZE;
    end
  end

  // Write commits on the edge that closes ACCESS; a reset edge aborts it.
  always_comb begin
    mem_we = HRESETn && (state == S_ACCESS) && write_q;
    mem_be = lane_enable(size_q, addr_q[1:0]);
  end

  ahb_lite_sram_array #(
    .MEM_WORDS(MEM_WORDS)
  ) u_sram (
    .clk  (HCLK),
    .we   (mem_we),
    .be   (mem_be),
    .addr (addr_q[AW+1:2]),
    .wdata(HWDATA),
    .rdata(mem_rdata)
  );

  always_comb begin
    HREADYOUT = !((state == S_WAIT) || (state == S_ERR1));
    HRESP     = ((state == S_ERR1) || (state == S_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    HRDATA    = ((state == S_ACCESS) && !write_q) ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_ahb_lite_mem_slave.sv
// Directed bench for ahb_lite_mem_slave. Two instances share the bus: one
// with WAIT_STATES=0 and one with WAIT_STATES=3; `which` selects the target.
// Observed data phase is packed as {HREADYOUT, HRESP, HRDATA}.
module tb_ahb_lite_mem_slave;

  localparam logic [33:0] OK0 = {1'b1, 1'b0, 32'h0};
  localparam logic [33:0] WT  = {1'b0, 1'b0, 32'h0};
  localparam logic [33:0] E1  = {1'b0, 1'b1, 32'h0};
  localparam logic [33:0] E2  = {1'b1, 1'b1, 32'h0};

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        hsel = 1'b0;
  logic [31:0] haddr = '0;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'b010;
  logic [1:0]  htrans = 2'b00;
  logic [31:0] hwdata = '0;
  logic        hready_ext = 1'b1;
  logic [2:0]  hburst = 3'b000;
  logic [3:0]  hprot = 4'h3;
  logic        hmastlock = 1'b0;
  logic        which = 1'b0;

  logic        sel0, sel3, ry0, ry3;
  logic [31:0] rd0, rd3;
  logic        ro0, ro3, rs0, rs3;
  logic [33:0] obs0, obs3, obs;

  int n_checks = 0;
  int n_pass   = 0;

  assign sel0 = hsel & ~which;
  assign sel3 = hsel & which;
  assign ry0  = hready_ext & ro0;
  assign ry3  = hready_ext & ro3;
  assign obs0 = {ro0, rs0, rd0};
  assign obs3 = {ro3, rs3, rd3};
  assign obs  = which ? obs3 : obs0;

  always #5 HCLK = ~HCLK;

  ahb_lite_mem_slave #(.MEM_WORDS(256), .WAIT_STATES(0)) dut0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(sel0), .HADDR(haddr), .HWRITE(hwrite),
    .HSIZE(hsize), .HBURST(hburst), .HTRANS(htrans), .HPROT(hprot),
    .HMASTLOCK(hmastlock), .HREADY(ry0), .HWDATA(hwdata),
    .HRDATA(rd0), .HREADYOUT(ro0), .HRESP(rs0)
  );

  ahb_lite_mem_slave #(.MEM_WORDS(256), .WAIT_STATES(3)) dut3 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(sel3), .HADDR(haddr), .HWRITE(hwrite),
    .HSIZE(hsize), .HBURST(hburst), .HTRANS(htrans), .HPROT(hprot),
    .HMASTLOCK(hmastlock), .HREADY(ry3), .HWDATA(hwdata),
    .HRDATA(rd3), .HREADYOUT(ro3), .HRESP(rs3)
  );

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic w,
                            input logic [2:0] sz, input logic [1:0] tr);
    hsel   = 1'b1;
    haddr  = a;
    hwrite = w;
    hsize  = sz;
    htrans = tr;
  endtask

  task automatic bus_idle();
    hsel   = 1'b0;
    htrans = 2'b00;
    hwrite = 1'b0;
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      hsel   = 1'($urandom);
      haddr  = $urandom;
      hwrite = 1'($urandom);
      hsize  = 3'($urandom);
      htrans = 2'($urandom);
      hwdata = $urandom;
      tick();
      n_checks++;
      if (obs0 !== OK0) $display("FAIL reset_ws0 cyc%0d got=%h exp=%h", i, obs0, OK0);
      else n_pass++;
      n_checks++;
      if (obs3 !== OK0) $display("FAIL reset_ws3 cyc%0d got=%h exp=%h", i, obs3, OK0);
      else n_pass++;
    end
    bus_idle();
    HRESETn = 1'b1;
    tick();
  endtask

  task automatic test_word_rw();
    which = 1'b0;
    addr_phase(32'h10, 1'b1, 3'b010, 2'b10);
    tick();
    n_checks++;
    if (obs !== OK0) $display("FAIL word_wr_phase got=%h exp=%h", obs, OK0);
    else n_pass++;
    hwdata = 32'hDEADBEEF;
    addr_phase(32'h10, 1'b0, 3'b010, 2'b10);
    tick();
    n_checks++;
    if (obs !== {2'b10, 32'hDEADBEEF}) $display("FAIL word_rd_phase got=%h exp=%h", obs, {2'b10, 32'hDEADBEEF});
    else n_pass++;
    bus_idle();
    tick();
    n_checks++;
    if (obs !== OK0) $display("FAIL word_after got=%h exp=%h", obs, OK0);
    else n_pass++;
  endtask

  task automatic test_lanes();
    which = 1'b0;
    addr_phase(32'h00, 1'b1, 3'b010, 2'b10);
    tick();
    hwdata = 32'h11111111;
    addr_phase(32'h20, 1'b1, 3'b010, 2'b10);
    tick();
    hwdata = 32'h00000000;
    addr_phase(32'h21, 1'b1, 3'b000, 2'b10);
    tick();
    n_checks++;
    if (obs !== OK0) $display("FAIL lanes_byte_phase got=%h exp=%h", obs, OK0);
    else n_pass++;
    hwdata = 32'h0000AA00;
    addr_phase(32'h22, 1'b1, 3'b001, 2'b10);
    tick();
    hwdata = 32'h12340000;
    addr_phase(32'h20, 1'b0, 3'b010, 2'b10);
    tick();
    n_checks++;
    if (obs !== {2'b10, 32'h1234AA00}) $display("FAIL lanes_readback got=%h exp=%h", obs, {2'b10, 32'h1234AA00});
    else n_pass++;
    bus_idle();
    tick();
  endtask

  task automatic test_errors();
    logic [31:0] e_addr [3];
    logic [2:0]  e_size [3];
    logic [31:0] c_addr [3];
    logic [31:0] c_data [3];
    e_addr = '{32'h12, 32'h20, 32'h400};
    e_size = '{3'b010, 3'b011, 3'b010};
    c_addr = '{32'h10, 32'h20, 32'h00};
    c_data = '{32'hDEADBEEF, 32'h1234AA00, 32'h11111111};
    which = 1'b0;
    for (int i = 0; i < 3; i++) begin
      addr_phase(e_addr[i], 1'b1, e_size[i], 2'b10);
      tick();
      n_checks++;
      if (obs !== E1) $display("FAIL err%0d_first got=%h exp=%h", i, obs, E1);
      else n_pass++;
      hwdata = 32'hFFFFFFFF;
      bus_idle();
      tick();
      n_checks++;
      if (obs !== E2) $display("FAIL err%0d_second got=%h exp=%h", i, obs, E2);
      else n_pass++;
      addr_phase(c_addr[i], 1'b0, 3'b010, 2'b10);
      tick();
      n_checks++;
      if (obs !== {2'b10, c_data[i]}) $display("FAIL err%0d_mem got=%h exp=%h", i, obs, {2'b10, c_data[i]});
      else n_pass++;
      bus_idle();
      tick();
    end
  endtask

  task automatic test_boundary();
    which = 1'b0;
    addr_phase(32'h3FC, 1'b1, 3'b010, 2'b10);
    tick();
    n_checks++;
    if (obs !== OK0) $display("FAIL last_word_wr got=%h exp=%h", obs, OK0);
    else n_pass++;
    hwdata = 32'h87654321;
    addr_phase(32'h3FC, 1'b0, 3'b010, 2'b10);
    tick();
    n_checks++;
    if (obs !== {2'b10, 32'h87654321}) $display("FAIL last_word_rd got=%h exp=%h", obs, {2'b10, 32'h87654321});
    else n_pass++;
    bus_idle();
    tick();
    // HREADY held low by another slave: the write must not be sampled.
    hready_ext = 1'b0;
    hwdata = 32'hBAD0BAD0;
    addr_phase(32'h10, 1'b1, 3'b010, 2'b10);
    tick();
    n_checks++;
    if (obs !== OK0) $display("FAIL hready_low_idle got=%h exp=%h", obs, OK0);
    else n_pass++;
    hready_ext = 1'b1;
    bus_idle();
    tick();
    addr_phase(32'h10, 1'b0, 3'b010, 2'b10);
    tick();
    n_checks++;
    if (obs !== {2'b10, 32'hDEADBEEF}) $display("FAIL hready_low_mem got=%h exp=%h", obs, {2'b10, 32'hDEADBEEF});
    else n_pass++;
    bus_idle();
    tick();
  endtask

  task automatic test_wait_states();
    which = 1'b1;
    addr_phase(32'h40, 1'b1, 3'b010, 2'b10);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (obs !== WT) $display("FAIL ws_wr_wait%0d got=%h exp=%h", i, obs, WT);
      else n_pass++;
      if (i == 0) begin
        hwdata = 32'hCAFEF00D;
        addr_phase(32'h40, 1'b0, 3'b010, 2'b10);
      end
    end
    tick();
    n_checks++;
    if (obs !== OK0) $display("FAIL ws_wr_access got=%h exp=%h", obs, OK0);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (obs !== WT) $display("FAIL ws_rd_wait%0d got=%h exp=%h", i, obs, WT);
      else n_pass++;
      if (i == 0) bus_idle();
    end
    tick();
    n_checks++;
    if (obs !== {2'b10, 32'hCAFEF00D}) $display("FAIL ws_rd_access got=%h exp=%h", obs, {2'b10, 32'hCAFEF00D});
    else n_pass++;
    addr_phase(32'h44, 1'b1, 3'b010, 2'b01);
    tick();
    n_checks++;
    if (obs !== OK0) $display("FAIL ws_busy got=%h exp=%h", obs, OK0);
    else n_pass++;
    addr_phase(32'h44, 1'b1, 3'b010, 2'b00);
    tick();
    n_checks++;
    if (obs !== OK0) $display("FAIL ws_idle got=%h exp=%h", obs, OK0);
    else n_pass++;
    bus_idle();
    tick();
  endtask

  task automatic test_reset_mid();
    which = 1'b1;
    addr_phase(32'h30, 1'b1, 3'b010, 2'b10);
    tick();
    hwdata = 32'h5555AAAA;
    bus_idle();
    tick();
    tick();
    tick();
    n_checks++;
    if (obs !== OK0) $display("FAIL rm_pre_access got=%h exp=%h", obs, OK0);
    else n_pass++;
    tick();
    addr_phase(32'h30, 1'b1, 3'b010, 2'b10);
    tick();
    hwdata = 32'hFFFF0000;
    bus_idle();
    tick();
    n_checks++;
    if (obs !== WT) $display("FAIL rm_wait got=%h exp=%h", obs, WT);
    else n_pass++;
    HRESETn = 1'b0;
    tick();
    n_checks++;
    if (obs !== OK0) $display("FAIL rm_reset got=%h exp=%h", obs, OK0);
    else n_pass++;
    HRESETn = 1'b1;
    tick();
    addr_phase(32'h30, 1'b0, 3'b010, 2'b10);
    tick();
    bus_idle();
    tick();
    tick();
    tick();
    n_checks++;
    if (obs !== {2'b10, 32'h5555AAAA}) $display("FAIL rm_readback got=%h exp=%h", obs, {2'b10, 32'h5555AAAA});
    else n_pass++;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_word_rw();
    test_lanes();
    test_errors();
    test_boundary();
    test_wait_states();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
